// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants and types for the UART command sequencer.
// Command byte values, counter widths and the two-state FSM encoding.
package uart_cmd_pkg;
    localparam int DATA_W     = 8;
    localparam int BYTE_CNT_W = 8;
    localparam int GAP_CNT_W  = 20;

    localparam logic [DATA_W-1:0] CMD_WR = 8'h55;
    localparam logic [DATA_W-1:0] CMD_RD = 8'hAA;

    typedef enum logic {
        IDLE    = 1'b0,
        WR_DATA = 1'b1
    } state_t;
endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream input and SDRAM-side strobes of the command sequencer.
// The master side feeds received bytes; the slave side is the sequencer.
interface uart_cmd_ctrl_if;
    import uart_cmd_pkg::*;

    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              wfifo_wr_en;
    logic [DATA_W-1:0] wfifo_wr_data;
    logic              wfifo_clr;
    logic              wr_trig;
    logic              rd_trig;
    logic              frame_err;

    modport master (
        output rx_data, rx_done,
        input  wfifo_wr_en, wfifo_wr_data, wfifo_clr, wr_trig, rd_trig, frame_err
    );

    modport slave (
        input  rx_data, rx_done,
        output wfifo_wr_en, wfifo_wr_data, wfifo_clr, wr_trig, rd_trig, frame_err
    );
endinterface

// File: rtl/uart_cmd_ctrl_timeout.sv
// Inter-byte gap watchdog for the write payload phase.
// expired fires on the clock that would carry gap_cnt to TIMEOUT_CYC-1, so the
// registered error lands exactly TIMEOUT_CYC cycles after the last byte strobe.
module uart_cmd_timeout
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 500_000
) (
    input  logic sclk_50M,
    input  logic s_rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP_C = GAP_CNT_W'(TIMEOUT_CYC - 2);

    logic [GAP_CNT_W-1:0] gap_cnt_r;

    // Expiry is suppressed by clear so a byte arriving on the boundary wins.
    always_comb begin
        expired = 1'b0;
        if (enable && !clear && (gap_cnt_r == LAST_GAP_C)) begin
            expired = 1'b1;
        end else begin
            expired = 1'b0;
        end
    end

    // Gap counter: held at zero outside the payload phase and after expiry.
    always_ff @(posedge sclk_50M or negedge s_rst_n) begin
        if (!s_rst_n) begin
            gap_cnt_r <= {GAP_CNT_W{1'b0}};
        end else if (clear || !enable || expired) begin
            gap_cnt_r <= {GAP_CNT_W{1'b0}};
        end else begin
            gap_cnt_r <= gap_cnt_r + {{(GAP_CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between the UART receiver and the SDRAM controller.
// Decodes write/read command bytes, streams write payloads into the FIFO, flags bad frames.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int DATA_NUM    = 4,
    parameter int TIMEOUT_CYC = 500_000
) (
    input  logic           sclk_50M,
    input  logic           s_rst_n,
    uart_cmd_ctrl_if.slave bus
);
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE_C = BYTE_CNT_W'(DATA_NUM - 1);

    state_t                state_r, state_s;
    logic [BYTE_CNT_W-1:0] byte_cnt_r, byte_cnt_s;
    logic [DATA_W-1:0]     wr_data_r, wr_data_s;
    logic                  wr_en_r, wr_en_s;
    logic                  clr_r, clr_s;
    logic                  wr_pend_r, wr_pend_s;
    logic                  wr_trig_r;
    logic                  rd_trig_r, rd_trig_s;
    logic                  frame_err_r, frame_err_s;
    logic                  gap_clear_s, gap_enable_s, expired_s;

    assign gap_enable_s = (state_r == WR_DATA);
    assign gap_clear_s  = bus.rx_done | ~gap_enable_s;

    uart_cmd_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .sclk_50M(sclk_50M),
        .s_rst_n (s_rst_n),
        .clear   (gap_clear_s),
        .enable  (gap_enable_s),
        .expired (expired_s)
    );

    // Next-state and next-output decode; in WR_DATA every byte is payload.
    always_comb begin
        state_s     = state_r;
        byte_cnt_s  = byte_cnt_r;
        wr_data_s   = wr_data_r;
        wr_en_s     = 1'b0;
        clr_s       = 1'b0;
        wr_pend_s   = 1'b0;
        rd_trig_s   = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.rx_done) begin
                    if (bus.rx_data == CMD_WR) begin
                        state_s    = WR_DATA;
                        byte_cnt_s = {BYTE_CNT_W{1'b0}};
                    end else if (bus.rx_data == CMD_RD) begin
                        rd_trig_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR_DATA: begin
                if (bus.rx_done) begin
                    wr_en_s    = 1'b1;
                    wr_data_s  = bus.rx_data;
                    byte_cnt_s = byte_cnt_r + {{(BYTE_CNT_W-1){1'b0}}, 1'b1};
                    if (byte_cnt_r == LAST_BYTE_C) begin
                        state_s   = IDLE;
                        wr_pend_s = 1'b1;
                    end else begin
                        state_s = WR_DATA;
                    end
                end else if (expired_s) begin
                    state_s     = IDLE;
                    frame_err_s = 1'b1;
                    clr_s       = 1'b1;
                end else begin
                    state_s = WR_DATA;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counter and output registers; wr_trig trails the last FIFO write by one cycle.
    always_ff @(posedge sclk_50M or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_r     <= IDLE;
            byte_cnt_r  <= {BYTE_CNT_W{1'b0}};
            wr_data_r   <= {DATA_W{1'b0}};
            wr_en_r     <= 1'b0;
            clr_r       <= 1'b0;
            wr_pend_r   <= 1'b0;
            wr_trig_r   <= 1'b0;
            rd_trig_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            byte_cnt_r  <= byte_cnt_s;
            wr_data_r   <= wr_data_s;
            wr_en_r     <= wr_en_s;
            clr_r       <= clr_s;
            wr_pend_r   <= wr_pend_s;
            wr_trig_r   <= wr_pend_r;
            rd_trig_r   <= rd_trig_s;
            frame_err_r <= frame_err_s;
        end
    end

    assign bus.wfifo_wr_en   = wr_en_r;
    assign bus.wfifo_wr_data = wr_data_r;
    assign bus.wfifo_clr     = clr_r;
    assign bus.wr_trig       = wr_trig_r;
    assign bus.rd_trig       = rd_trig_r;
    assign bus.frame_err     = frame_err_r;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: each observed output pulse is an event
// (cycle, kind, data) compared against events predicted by a frame-level model.
module tb_uart_cmd_ctrl;
    localparam int DN = 4;
    localparam int T  = 100;

    // event kinds
    localparam int K_WR = 0, K_CLR = 1, K_WTRIG = 2, K_RTRIG = 3, K_ERR = 4;

    logic clk = 1'b0;
    logic s_rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    longint obs_q[$];
    longint exp_q[$];

    bit m_in_frame = 1'b0;
    int m_got = 0;
    int m_last = 0;

    uart_cmd_ctrl_if bus_if ();

    uart_cmd_ctrl #(.DATA_NUM(DN), .TIMEOUT_CYC(T)) dut (
        .sclk_50M(clk),
        .s_rst_n (s_rst_n),
        .bus     (bus_if)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint ev(input int c, input int k, input logic [7:0] d);
        return (longint'(c) << 16) | (longint'(k) << 8) | longint'(d);
    endfunction

    // record every output pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (s_rst_n) begin
            if (bus_if.wfifo_wr_en) obs_q.push_back(ev(cyc, K_WR, bus_if.wfifo_wr_data));
            if (bus_if.wfifo_clr)   obs_q.push_back(ev(cyc, K_CLR, 8'h00));
            if (bus_if.wr_trig)     obs_q.push_back(ev(cyc, K_WTRIG, 8'h00));
            if (bus_if.rd_trig)     obs_q.push_back(ev(cyc, K_RTRIG, 8'h00));
            if (bus_if.frame_err)   obs_q.push_back(ev(cyc, K_ERR, 8'h00));
        end
    end

    // Frame model: a pending frame times out T cycles after its last strobe unless
    // the next strobe arrives no later than T-1 cycles after it.
    task automatic model_flush(input int c);
        if (m_in_frame && (c > m_last + T - 1)) begin
            exp_q.push_back(ev(m_last + T, K_CLR, 8'h00));
            exp_q.push_back(ev(m_last + T, K_ERR, 8'h00));
            m_in_frame = 1'b0;
        end
    endtask

    task automatic model_rx(input int c, input logic [7:0] b);
        model_flush(c);
        if (!m_in_frame) begin
            if (b == 8'h55) begin
                m_in_frame = 1'b1;
                m_got      = 0;
                m_last     = c;
            end else if (b == 8'hAA) begin
                exp_q.push_back(ev(c + 1, K_RTRIG, 8'h00));
            end else begin
                exp_q.push_back(ev(c + 1, K_ERR, 8'h00));
            end
        end else begin
            exp_q.push_back(ev(c + 1, K_WR, b));
            m_got  = m_got + 1;
            m_last = c;
            if (m_got == DN) begin
                exp_q.push_back(ev(c + 2, K_WTRIG, 8'h00));
                m_in_frame = 1'b0;
            end
        end
    endtask

    task automatic model_reset(input int c);
        longint keep[$];
        foreach (exp_q[i]) if ((exp_q[i] >> 16) < longint'(c)) keep.push_back(exp_q[i]);
        exp_q = keep;
        m_in_frame = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus_if.rx_done = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus_if.rx_done = 1'b1;
        bus_if.rx_data = b;
        model_rx(cyc, b);
    endtask

    task automatic test_reset();
        bus_if.rx_done = 1'b0;
        bus_if.rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_if.wfifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset wfifo_wr_en got %b want 0", bus_if.wfifo_wr_en); end
        checks++; if (bus_if.wfifo_wr_data !== 8'h00) begin errors++; $display("FAIL reset wfifo_wr_data got %h want 00", bus_if.wfifo_wr_data); end
        checks++; if (bus_if.wfifo_clr !== 1'b0) begin errors++; $display("FAIL reset wfifo_clr got %b want 0", bus_if.wfifo_clr); end
        checks++; if (bus_if.wr_trig !== 1'b0) begin errors++; $display("FAIL reset wr_trig got %b want 0", bus_if.wr_trig); end
        checks++; if (bus_if.rd_trig !== 1'b0) begin errors++; $display("FAIL reset rd_trig got %b want 0", bus_if.rd_trig); end
        checks++; if (bus_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err got %b want 0", bus_if.frame_err); end
        @(negedge clk);
        s_rst_n = 1'b1;
        idle(10);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL reset_quiet events got %0d want 0", obs_q.size()); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_write();
        logic [7:0] seq [5];
        seq = '{8'h55, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (seq[i]) begin send(seq[i]); idle(19); end
        idle(T + 5);
        model_flush(cyc);
        exp_q.sort(); obs_q.sort();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL write count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL write evt%0d got cyc=%0d kind=%0d data=%0h want cyc=%0d kind=%0d data=%0h", i, obs_q[i] >> 16, (obs_q[i] >> 8) & 255, obs_q[i] & 255, exp_q[i] >> 16, (exp_q[i] >> 8) & 255, exp_q[i] & 255); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_read_and_bad();
        logic [7:0] seq [7];
        seq = '{8'hAA, 8'h3C, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
        foreach (seq[i]) begin send(seq[i]); idle(19); end
        idle(T + 5);
        model_flush(cyc);
        exp_q.sort(); obs_q.sort();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rd_bad count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rd_bad evt%0d got cyc=%0d kind=%0d data=%0h want cyc=%0d kind=%0d data=%0h", i, obs_q[i] >> 16, (obs_q[i] >> 8) & 255, obs_q[i] & 255, exp_q[i] >> 16, (exp_q[i] >> 8) & 255, exp_q[i] & 255); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout_and_race();
        send(8'h55); idle(19); send(8'h11); idle(19); send(8'h22);
        idle(T + 10);
        send(8'hAA); idle(5);
        // byte lands on the last cycle before expiry, then again one cycle late
        send(8'h55); idle(T - 2); send(8'h33); idle(T - 2); send(8'h44);
        idle(T - 1); send(8'h5A);
        idle(T + 5);
        model_flush(cyc);
        exp_q.sort(); obs_q.sort();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout evt%0d got cyc=%0d kind=%0d data=%0h want cyc=%0d kind=%0d data=%0h", i, obs_q[i] >> 16, (obs_q[i] >> 8) & 255, obs_q[i] & 255, exp_q[i] >> 16, (exp_q[i] >> 8) & 255, exp_q[i] & 255); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mid_reset();
        send(8'h55); idle(19); send(8'h11);
        @(posedge clk);
        #3;
        s_rst_n = 1'b0;
        model_reset(cyc);
        #1;
        checks++; if (bus_if.wfifo_wr_en !== 1'b0) begin errors++; $display("FAIL midrst wfifo_wr_en got %b want 0", bus_if.wfifo_wr_en); end
        checks++; if (bus_if.wfifo_wr_data !== 8'h00) begin errors++; $display("FAIL midrst wfifo_wr_data got %h want 00", bus_if.wfifo_wr_data); end
        bus_if.rx_done = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        s_rst_n = 1'b1;
        idle(5);
        send(8'hAA); idle(T + 5);
        model_flush(cyc);
        exp_q.sort(); obs_q.sort();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst evt%0d got cyc=%0d kind=%0d data=%0h want cyc=%0d kind=%0d data=%0h", i, obs_q[i] >> 16, (obs_q[i] >> 8) & 255, obs_q[i] & 255, exp_q[i] >> 16, (exp_q[i] >> 8) & 255, exp_q[i] & 255); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] b;
        int g;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(3, 0))
                0, 1:    b = 8'h55;
                2:       b = 8'hAA;
                default: b = 8'($urandom);
            endcase
            g = ($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(T + 20, 1));
            idle(g);
            send(b);
        end
        idle(T + 5);
        model_flush(cyc);
        exp_q.sort(); obs_q.sort();
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL random count got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random evt%0d got cyc=%0d kind=%0d data=%0h want cyc=%0d kind=%0d data=%0h", i, obs_q[i] >> 16, (obs_q[i] >> 8) & 255, obs_q[i] & 255, exp_q[i] >> 16, (exp_q[i] >> 8) & 255, exp_q[i] & 255); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_and_bad();
        test_timeout_and_race();
        test_mid_reset();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Byte-level command sequencer between the UART receiver and the SDRAM controller. It consumes the receiver's byte stream and decodes one-byte commands: a write command is followed by a fixed-length payload, which it streams into the SDRAM write-data FIFO and then triggers an SDRAM write burst. A read command triggers an SDRAM read burst immediately. Malformed or stalled frames are dropped, the FIFO is flushed, and an error is flagged.

## Interface
Parameters:
- DATA_NUM, 4: payload bytes per write frame; legal range 1..255.
- TIMEOUT_CYC, 500_000: allowed gap between payload bytes, in clocks (10 ms at 50 MHz); legal range 2..2^20-1.

Ports:
- sclk_50M  in  1  system clock, 50 MHz.
- s_rst_n  in  1  reset: asynchronous, active-low.
- rx_data  in  8  received byte; valid only while rx_done is high.
- rx_done  in  1  one-cycle byte-valid strobe from the UART receiver.
- wfifo_wr_en  out  1  one-cycle write strobe to the SDRAM write FIFO.
- wfifo_wr_data  out  8  byte written to the FIFO; valid while wfifo_wr_en is high.
- wfifo_clr  out  1  one-cycle flush strobe; discards a partial payload.
- wr_trig  out  1  one-cycle request for an SDRAM write burst.
- rd_trig  out  1  one-cycle request for an SDRAM read burst.
- frame_err  out  1  one-cycle error strobe (unknown command or timeout).

## Operation
- Command bytes: CMD_WR = 8'h55, CMD_RD = 8'hAA.
- States:
  - IDLE: waiting for a command byte.
  - WR_DATA: collecting the write payload.
- IDLE, on rx_done:
  - CMD_WR: go to WR_DATA; clear byte_cnt and gap_cnt.
  - CMD_RD: pulse rd_trig; stay in IDLE.
  - Any other byte: pulse frame_err; stay in IDLE.
- WR_DATA, on rx_done:
  - Every byte is payload, including 8'h55 and 8'hAA.
  - Pulse wfifo_wr_en; wfifo_wr_data = rx_data.
  - Increment byte_cnt; clear gap_cnt.
  - If byte_cnt == DATA_NUM-1: go to IDLE and schedule wr_trig.
- WR_DATA, no rx_done:
  - gap_cnt increments each cycle.
  - When gap_cnt == TIMEOUT_CYC-1: pulse frame_err and wfifo_clr together, go to IDLE, never pulse wr_trig.
- Counters:
  - byte_cnt is 8 bits, unsigned, cleared on entry to WR_DATA.
  - gap_cnt is 20 bits, unsigned, saturation-free; it is held at 0 in IDLE.
- rx_done and timeout in the same cycle: the byte wins; no timeout is taken.
- No gap timeout in IDLE; the block waits indefinitely for a command.
- Reset, at any time including mid-frame: state IDLE, both counters 0, all outputs 0. A partial payload already in the FIFO is not flushed by this block; the system reset clears the FIFO.

## Timing
- All outputs are registered. Reset value of every output is 0.
- For rx_done high at cycle N:
  - wfifo_wr_en, wfifo_wr_data, rd_trig and frame_err assert at N+1.
  - For the final payload byte, wr_trig asserts at N+2, one cycle after the last wfifo_wr_en, so the FIFO holds the complete payload when the trigger arrives.
- Timeout: frame_err and wfifo_clr assert TIMEOUT_CYC cycles after the last rx_done in WR_DATA. For the CMD_WR byte, "last rx_done" is the command byte itself.
- Every output pulse lasts exactly one cycle.
- rx_done strobes are at least one UART byte time apart. Back-to-back rx_done, one cycle apart, must still be handled correctly: each strobe yields its own wfifo_wr_en.
- No output ever asserts without a preceding rx_done or timeout.

## Structure
- Package uart_cmd_pkg holds:
  - CMD_WR and CMD_RD.
  - State encoding: IDLE = 1'b0, WR_DATA = 1'b1.
  - Counter widths: 8 for byte_cnt, 20 for gap_cnt.
- One sub-module is natural: uart_cmd_timeout. It contains gap_cnt with inputs clear, enable and TIMEOUT_CYC, and produces a one-cycle expired flag. The FSM, byte counter and output registers stay in uart_cmd_ctrl.

## Test plan
Bench settings: DATA_NUM = 4, TIMEOUT_CYC = 100.
- Good write: bytes 55, 11, 22, 33, 44 at 20-cycle spacing -> four wfifo_wr_en pulses carrying 11, 22, 33, 44; wr_trig exactly one cycle after the 44 strobe; no frame_err.
- Read: byte AA in IDLE -> rd_trig at N+1; nothing else asserts.
- Bad command: byte 3C -> frame_err at N+1. A following 55, AA, 55, AA, 55 -> four FIFO writes with data AA, 55, AA, 55, then wr_trig.
- Timeout: 55, 11, 22, then silence -> frame_err and wfifo_clr together 100 cycles after the 22 strobe; no wr_trig; a later AA yields rd_trig.
- Race: rx_done carrying byte 33 arrives exactly on the cycle gap_cnt reaches 99 -> byte accepted, no timeout.
- Reset: assert s_rst_n low after 55, 11 -> all outputs 0 immediately. After release, AA -> rd_trig, confirming the block restarted in IDLE.
